imem_controller: RTL and testbench
==================================

# imem_controller

Run-control and arbitration block for the 8-bit four-register CPU's 32-byte instruction memory. It owns the instruction store, serves combinational fetches to `Main` on its `ReadAddress`/`instruction` path, and shares the store with a program loader. While the loader holds the store the CPU is stalled, and the CPU is restarted when the loader releases it. A single-step mode gates CPU progress to one instruction per debounced button press.

## Interface
- `DEPTH`, 32, instruction bytes held.
- `AW`, 5, loader address width (log2 `DEPTH`).
- `FILL`, 8'h00, byte returned for out-of-range fetch.
- `clk50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  8  CPU fetch address (PC).
- `cpu_instr`  out  8  instruction byte to CPU.
- `cpu_en`  out  1  CPU advance enable; CPU holds state when 0.
- `cpu_restart`  out  1  one-cycle pulse; CPU clears PC.
- `ld_req`  in  1  loader requests the store (level).
- `ld_grant`  out  1  loader owns the store.
- `ld_valid`  in  1  loader write beat valid.
- `ld_ready`  out  1  controller accepts a write this cycle.
- `ld_addr`  in  AW  write address.
- `ld_data`  in  8  write data.
- `step_mode`  in  1  1 = single-step, 0 = free run.
- `step_btn`  in  1  raw step button, asynchronous to the clock.
- `addr_err`  out  1  sticky flag: a fetch went out of range.

## Operation
- Store: `DEPTH` × 8 flops, read asynchronously, written synchronously.
- Reset: the store loads the package constant `BOOT_IMAGE`.
- Fetch: `cpu_instr = mem[cpu_addr]` when `cpu_addr < DEPTH`.
  - Otherwise `cpu_instr` = `FILL` and `addr_err` sets; it clears only on reset.
  - `cpu_instr` is valid in every state. The CPU is stalled during LOAD, so reads there are don't-care.
- State machine: RUN, DRAIN, LOAD.
  - RUN, `ld_req` = 1 → DRAIN. `cpu_en` = 0 from the next cycle.
  - DRAIN → LOAD unconditionally. It lasts exactly one cycle so the in-flight CPU write completes.
  - LOAD: `ld_grant` = `ld_ready` = 1. Each cycle with `ld_valid` writes `mem[ld_addr] = ld_data`.
  - LOAD, `ld_req` = 0 → RUN. `cpu_restart` pulses in the first RUN cycle. `cpu_en` resumes the following cycle.
- `cpu_en` in RUN:
  - free run: 1 every cycle.
  - step mode: 1 for exactly one cycle per synchronized rising edge of `step_btn`.
- Boundary rules:
  - `ld_valid` outside LOAD: ignored, no write.
  - `ld_req` falls in the same cycle as `ld_valid`: the write happens. `ld_ready` is still 1 that cycle.
  - `ld_req` and a step pulse in the same cycle: `ld_req` wins and the step pulse is discarded.
  - Step edges during DRAIN/LOAD are discarded, not queued.
  - Toggling `step_mode` mid-run takes effect the next cycle.
  - Reset mid-LOAD: → RUN, store reloads `BOOT_IMAGE`, no `cpu_restart` pulse.

## Timing
- Reset values: state RUN, `cpu_en` 0, `cpu_restart` 0, `ld_grant` 0, `ld_ready` 0, `addr_err` 0.
- First cycle after reset release with `step_mode` = 0: `cpu_en` = 1.
- All outputs except `cpu_instr` are registered.
- Load handshake, with `ld_req` first sampled high at edge N:
  - N+1: DRAIN, `cpu_en` = 0.
  - N+2: LOAD, `ld_grant`/`ld_ready` = 1.
- Write visibility: a write at edge K is visible on `cpu_instr` after edge K.
- Release, with `ld_req` sampled low at edge M:
  - M+1: `ld_grant`/`ld_ready` = 0, `cpu_restart` = 1.
  - M+2: `cpu_restart` = 0, `cpu_en` = 1 (free run).
- Step latency: two-flop synchronizer plus edge detect. `cpu_en` goes high 3 edges after `step_btn` is first sampled high, for 1 cycle.

## Structure
- Package `imem_pkg` holds:
  - `DEPTH`/`AW` defaults.
  - state enum {RUN, DRAIN, LOAD}.
  - opcode constants: add = 2'b00, lw = 2'b01, sw = 2'b10, j = 2'b11.
  - `BOOT_IMAGE` (32 bytes).
- One sub-module, `step_sync`: 2-FF synchronizer plus rising-edge pulse, async active-low reset.

## Test plan
- Reset, then fetch addresses 0..31 → `cpu_instr` equals `BOOT_IMAGE` bytes. Fetch address 40 → 8'h00 and `addr_err` = 1, held after returning to address 0.
- `ld_req` high at N → `cpu_en` 0 at N+1, `ld_grant` 1 at N+2. Write 8'h4D to addr 3 → `cpu_instr` at `cpu_addr` 3 reads 8'h4D the next cycle.
- Drop `ld_req` with `ld_valid` high, writing 8'hC3 to addr 5 → mem[5] = 8'hC3, `cpu_restart` exactly 1 cycle, then `cpu_en` = 1.
- `step_mode` = 1, three `step_btn` presses → exactly three 1-cycle `cpu_en` pulses, each 3 edges after its press.
- `ld_req` and a step pulse coincide → no `cpu_en` pulse, DRAIN entered.
- `reset` low during LOAD after writing addr 0 = 8'hFF → mem[0] returns to `BOOT_IMAGE[0]`, state RUN, no `cpu_restart`.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants, types and the boot image for the instruction memory controller.
package imem_pkg;

  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam logic [7:0] FILL = 8'h00;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Instruction byte: opcode in the top two bits, operand fields below.
  function automatic logic [7:0] enc(input logic [1:0] op, input logic [5:0] arg);
    return {op, arg};
  endfunction

  // Program present in the store after every reset.
  localparam logic [7:0] BOOT_IMAGE [DEPTH] = '{
    enc(OP_LW,  6'h05), enc(OP_ADD, 6'h16), enc(OP_SW,  6'h0A), enc(OP_ADD, 6'h27),
    enc(OP_J,   6'h10), enc(OP_LW,  6'h19), enc(OP_ADD, 6'h03), enc(OP_SW,  6'h1C),
    enc(OP_LW,  6'h21), enc(OP_SW,  6'h32), enc(OP_ADD, 6'h1E), enc(OP_LW,  6'h34),
    enc(OP_J,   6'h25), enc(OP_ADD, 6'h38), enc(OP_SW,  6'h2F), enc(OP_LW,  6'h0B),
    enc(OP_SW,  6'h12), enc(OP_ADD, 6'h06), enc(OP_J,   6'h07), enc(OP_LW,  6'h1D),
    enc(OP_ADD, 6'h2A), enc(OP_J,   6'h31), enc(OP_SW,  6'h03), enc(OP_ADD, 6'h14),
    enc(OP_LW,  6'h2E), enc(OP_SW,  6'h39), enc(OP_ADD, 6'h0C), enc(OP_SW,  6'h24),
    enc(OP_ADD, 6'h37), enc(OP_J,   6'h18), enc(OP_LW,  6'h10), enc(OP_J,   6'h00)
  };

endpackage

// File: rtl/imem_controller_step_sync.sv
// Step button conditioner: two-flop synchronizer followed by a registered
// rising-edge detector producing a one-cycle pulse.
module step_sync (
  input  logic clk50,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize the raw button and emit one pulse per rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/imem_controller.sv
// Instruction store with CPU fetch port, loader write port and run control
// (free run, single step, stall while the loader owns the store).
module imem_controller #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW = imem_pkg::AW,
  parameter logic [7:0] FILL = imem_pkg::FILL
) (
  input  logic          clk50,
  input  logic          reset,
  input  logic [7:0]    cpu_addr,
  output logic [7:0]    cpu_instr,
  output logic          cpu_en,
  output logic          cpu_restart,
  input  logic          ld_req,
  output logic          ld_grant,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          step_mode,
  input  logic          step_btn,
  output logic          addr_err
);

  import imem_pkg::*;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  logic [7:0] mem [DEPTH];
  state_t     state;
  state_t     state_next;
  logic       cpu_en_next;
  logic       restart_next;
  logic       grant_next;
  logic       step_pulse;
  logic       in_range;
  logic       wr_en;

  step_sync u_step_sync (
    .clk50 (clk50),
    .reset (reset),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  assign in_range  = (cpu_addr < DEPTH_B);
  assign cpu_instr = in_range ? mem[cpu_addr[AW-1:0]] : FILL;
  assign wr_en     = (state == LOAD) && ld_valid;

  // Next state and next values of the registered control outputs.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (ld_req) state_next = DRAIN;
      DRAIN:   state_next = LOAD;
      LOAD:    if (!ld_req) state_next = RUN;
      default: state_next = RUN;
    endcase
    grant_next   = (state_next == LOAD);
    restart_next = (state == LOAD) && (state_next == RUN);
    // A loader request in the same cycle swallows any step pulse; the first
    // RUN cycle after a load is reserved for the restart pulse.
    cpu_en_next  = (state == RUN) && (state_next == RUN) && (!step_mode || step_pulse);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cpu_en      <= 1'b0;
      cpu_restart <= 1'b0;
      ld_grant    <= 1'b0;
      ld_ready    <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_next;
      cpu_en      <= cpu_en_next;
      cpu_restart <= restart_next;
      ld_grant    <= grant_next;
      ld_ready    <= grant_next;
      addr_err    <= addr_err | ~in_range;
    end
  end

  // Instruction store: boot image on reset, loader writes while in LOAD.
  // NOTE: the store is reset on purpose because it must come up holding the boot program.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= BOOT_IMAGE[i % imem_pkg::DEPTH];
      end
    end else if (wr_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_controller.sv
// Directed bench for imem_controller: boot image, out-of-range fetch, load
// handshake, release, single step, request/step collision, reset mid-load.
module tb_imem_controller;

  logic       clk50;
  logic       reset;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_instr;
  logic       cpu_en;
  logic       cpu_restart;
  logic       ld_req;
  logic       ld_grant;
  logic       ld_valid;
  logic       ld_ready;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic       step_mode;
  logic       step_btn;
  logic       addr_err;

  int total = 0;
  int bad = 0;

  logic [7:0] boot [32] = '{
    8'h45, 8'h16, 8'h8A, 8'h27, 8'hD0, 8'h59, 8'h03, 8'h9C,
    8'h61, 8'hB2, 8'h1E, 8'h74, 8'hE5, 8'h38, 8'hAF, 8'h4B,
    8'h92, 8'h06, 8'hC7, 8'h5D, 8'h2A, 8'hF1, 8'h83, 8'h14,
    8'h6E, 8'hB9, 8'h0C, 8'hA4, 8'h37, 8'hD8, 8'h50, 8'hC0
  };

  imem_controller dut (
    .clk50       (clk50),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_instr   (cpu_instr),
    .cpu_en      (cpu_en),
    .cpu_restart (cpu_restart),
    .ld_req      (ld_req),
    .ld_grant    (ld_grant),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .step_mode   (step_mode),
    .step_btn    (step_btn),
    .addr_err    (addr_err)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One active edge, then park on the falling edge to sample and drive.
  task automatic tick();
    @(posedge clk50);
    @(negedge clk50);
  endtask

  initial begin
    reset = 1'b0;
    cpu_addr = 8'd0;
    ld_req = 1'b0;
    ld_valid = 1'b0;
    ld_addr = 5'd0;
    ld_data = 8'd0;
    step_mode = 1'b0;
    step_btn = 1'b0;

    @(negedge clk50);
    check("rst_cpu_en", cpu_en, 1'b0);
    check("rst_restart", cpu_restart, 1'b0);
    check("rst_grant", ld_grant, 1'b0);
    check("rst_ready", ld_ready, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);

    reset = 1'b1;
    tick();
    check("first_cpu_en", cpu_en, 1'b1);

    // Boot image readback over the whole store.
    for (int i = 0; i < 32; i++) begin
      cpu_addr = 8'(i);
      #1;
      check($sformatf("boot_%0d", i), cpu_instr, boot[i]);
    end

    // Out-of-range fetch and sticky error flag.
    cpu_addr = 8'd40;
    #1;
    check("oor_fill", cpu_instr, 8'h00);
    tick();
    check("oor_err_set", addr_err, 1'b1);
    cpu_addr = 8'd0;
    tick();
    check("oor_err_held", addr_err, 1'b1);
    check("addr0_after_oor", cpu_instr, 8'h45);

    // Loader write outside LOAD is dropped.
    ld_valid = 1'b1;
    ld_addr = 5'd7;
    ld_data = 8'hEE;
    tick();
    ld_valid = 1'b0;
    cpu_addr = 8'd7;
    #1;
    check("run_write_ignored", cpu_instr, 8'h9C);

    // Load handshake.
    ld_req = 1'b1;
    tick();
    check("drain_cpu_en", cpu_en, 1'b0);
    check("drain_grant", ld_grant, 1'b0);
    tick();
    check("load_grant", ld_grant, 1'b1);
    check("load_ready", ld_ready, 1'b1);
    check("load_cpu_en", cpu_en, 1'b0);
    ld_valid = 1'b1;
    ld_addr = 5'd3;
    ld_data = 8'h4D;
    tick();
    ld_valid = 1'b0;
    cpu_addr = 8'd3;
    #1;
    check("load_write3", cpu_instr, 8'h4D);

    // Release with a final write in the same cycle.
    ld_req = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 5'd5;
    ld_data = 8'hC3;
    tick();
    ld_valid = 1'b0;
    check("rel_restart", cpu_restart, 1'b1);
    check("rel_cpu_en", cpu_en, 1'b0);
    check("rel_grant", ld_grant, 1'b0);
    check("rel_ready", ld_ready, 1'b0);
    cpu_addr = 8'd5;
    #1;
    check("rel_write5", cpu_instr, 8'hC3);
    tick();
    check("rel_restart_end", cpu_restart, 1'b0);
    check("rel_cpu_en_on", cpu_en, 1'b1);

    // Single step: one pulse per press, three edges after the press is sampled.
    step_mode = 1'b1;
    tick();
    check("step_mode_gate", cpu_en, 1'b0);
    for (int p = 0; p < 3; p++) begin
      step_btn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        tick();
        check($sformatf("step%0d_k%0d", p, k), cpu_en, (k == 4) ? 1'b1 : 1'b0);
      end
      step_btn = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("step%0d_rel%0d", p, k), cpu_en, 1'b0);
      end
    end

    // Loader request coincides with a step pulse: request wins.
    step_btn = 1'b1;
    tick();
    tick();
    tick();
    ld_req = 1'b1;
    tick();
    check("coll_cpu_en", cpu_en, 1'b0);
    check("coll_grant", ld_grant, 1'b0);
    tick();
    check("coll_load_grant", ld_grant, 1'b1);
    check("coll_cpu_en2", cpu_en, 1'b0);
    step_btn = 1'b0;

    // Reset in the middle of LOAD.
    ld_valid = 1'b1;
    ld_addr = 5'd0;
    ld_data = 8'hFF;
    tick();
    ld_valid = 1'b0;
    cpu_addr = 8'd0;
    #1;
    check("load_write0", cpu_instr, 8'hFF);
    reset = 1'b0;
    #1;
    check("rstld_instr0", cpu_instr, 8'h45);
    check("rstld_grant", ld_grant, 1'b0);
    check("rstld_restart", cpu_restart, 1'b0);
    check("rstld_addr_err", addr_err, 1'b0);
    ld_req = 1'b0;
    step_mode = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rstld_run_cpu_en", cpu_en, 1'b1);
    check("rstld_no_restart", cpu_restart, 1'b0);
    tick();
    check("rstld_no_restart2", cpu_restart, 1'b0);
    cpu_addr = 8'd3;
    #1;
    check("rstld_instr3", cpu_instr, 8'h27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
